// File: rtl/anim_pkg.sv
// Shared types for the animation controller: game FSM states, coordinate
// width and the axis-aligned box description used for hit testing.
package anim_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Box edges; x1/y1 are the low edges, x2/y2 the high edges.
    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational overlap test of two boxes. Edges that merely touch do not
// count as overlapping, so every comparison is strict.
module rect_overlap
    import anim_pkg::*;
(
    input  box_t a_i,
    input  box_t b_i,
    output logic overlap_o
);

    assign overlap_o = (a_i.x1 < b_i.x2) && (b_i.x1 < a_i.x2) &&
                       (a_i.y1 < b_i.y2) && (b_i.y1 < a_i.y2);

endmodule

// File: rtl/anim_ctrl.sv
// Game animation controller: IDLE/RUN/PAUSE/OVER sequencing, frame divider
// producing the sprite animation strobe, saturating score and sticky hit.
// Optional feature macro: ANIM_CTRL_SPEEDUP_EN -- when defined, the divider
// shortens by one for every 256 points scored (never below 1).
module anim_ctrl
    import anim_pkg::*;
#(
    parameter int D_WIDTH   = 640,
    parameter int D_HEIGHT  = 480,
    parameter int FRAME_DIV = 1,
    parameter int SCORE_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic [COORD_W-1:0] i_p_x1,
    input  logic [COORD_W-1:0] i_p_x2,
    input  logic [COORD_W-1:0] i_p_y1,
    input  logic [COORD_W-1:0] i_p_y2,
    input  logic [COORD_W-1:0] i_o_x1,
    input  logic [COORD_W-1:0] i_o_x2,
    input  logic [COORD_W-1:0] i_o_y1,
    input  logic [COORD_W-1:0] i_o_y2,
    output logic               o_ani_stb,
    output logic               o_animate,
    output logic               o_sprite_rst,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_hit
);

    localparam int                 DIV_W    = 4;
    localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(D_WIDTH);
    localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(D_HEIGHT);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               hit_q, hit_d;
    logic               stb_q, stb_d;
    logic               srst_q, srst_d;
    logic               animate_q;

    box_t               p_box, o_box;
    logic               collide;
    logic               oob;
    logic [DIV_W-1:0]   eff_div;

    assign p_box = '{x1: i_p_x1, x2: i_p_x2, y1: i_p_y1, y2: i_p_y2};
    assign o_box = '{x1: i_o_x1, x2: i_o_x2, y1: i_o_y1, y2: i_o_y2};

    rect_overlap u_overlap (
        .a_i       (p_box),
        .b_i       (o_box),
        .overlap_o (collide)
    );

    // Player touching or leaving the display edge ends the game.
    assign oob = (i_p_y1 == '0) || (i_p_y2 >= HEIGHT_C) ||
                 (i_p_x1 == '0) || (i_p_x2 >= WIDTH_C);

`ifdef ANIM_CTRL_SPEEDUP_EN
    // One speed level per 256 points; the divider bottoms out at 1.
    logic [SCORE_W-1:0] level;
    assign level   = score_q >> 8;
    assign eff_div = (level >= SCORE_W'(FRAME_DIV)) ? DIV_W'(1)
                                                    : DIV_W'(FRAME_DIV - int'(level));
`else
    assign eff_div = DIV_W'(FRAME_DIV);
`endif

    // Next-state, divider, score and hit decisions for the game FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        div_d   = div_q;
        score_d = score_q;
        hit_d   = hit_q;
        stb_d   = 1'b0;
        srst_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                // Start outranks a simultaneous pause; pause is meaningless here.
                if (i_start) begin
                    state_d = ST_RUN;
                    srst_d  = 1'b1;
                    score_d = '0;
                    hit_d   = 1'b0;
                    div_d   = '0;
                end
            end
            ST_RUN: begin
                if (i_frame && (collide || oob)) begin
                    // A hit outranks pause and swallows this frame's step.
                    state_d = ST_OVER;
                    hit_d   = 1'b1;
                end else begin
                    if (i_frame) begin
                        // >= keeps the divider bounded if the speedup shrank it.
                        if (div_q >= eff_div - DIV_W'(1)) begin
                            div_d = '0;
                            stb_d = 1'b1;
                            if (score_q != '1) begin
                                score_d = score_q + SCORE_W'(1);
                            end
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                    if (i_pause) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (i_pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset also discards any pending strobe.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            score_q   <= '0;
            hit_q     <= 1'b0;
            stb_q     <= 1'b0;
            srst_q    <= 1'b1;
            animate_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            score_q   <= score_d;
            hit_q     <= hit_d;
            stb_q     <= stb_d;
            srst_q    <= srst_d;
            animate_q <= (state_d == ST_RUN);
        end
    end

    assign o_ani_stb    = stb_q;
    assign o_animate    = animate_q;
    assign o_sprite_rst = srst_q;
    assign o_state      = state_q;
    assign o_score      = score_q;
    assign o_hit        = hit_q;

endmodule

// File: tb/tb_anim_ctrl.sv
// Self-checking bench for anim_ctrl: directed scenarios plus a random phase,
// all compared every cycle against a behavioural game model.
module tb_anim_ctrl;

    localparam int FD = 3;

    logic        i_clk = 1'b0;
    logic        i_rst, i_frame, i_start, i_pause;
    logic [11:0] p_x1, p_x2, p_y1, p_y2;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;

    logic        stb, animate, srst, hit;
    logic [1:0]  state;
    logic [15:0] score;
    logic        s_stb, s_animate, s_srst, s_hit;
    logic [1:0]  s_state;
    logic [3:0]  s_score;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the game.
    int m_state = 0, m_phase = 0, m_score = 0, m_score4 = 0;
    int m_stb = 0, m_srst = 0, m_hit = 0;
    int stb_seen = 0;

    always #5 i_clk = ~i_clk;

    anim_ctrl #(.D_WIDTH(640), .D_HEIGHT(480), .FRAME_DIV(FD), .SCORE_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame(i_frame), .i_start(i_start), .i_pause(i_pause),
        .i_p_x1(p_x1), .i_p_x2(p_x2), .i_p_y1(p_y1), .i_p_y2(p_y2),
        .i_o_x1(o_x1), .i_o_x2(o_x2), .i_o_y1(o_y1), .i_o_y2(o_y2),
        .o_ani_stb(stb), .o_animate(animate), .o_sprite_rst(srst),
        .o_state(state), .o_score(score), .o_hit(hit)
    );

    anim_ctrl #(.D_WIDTH(640), .D_HEIGHT(480), .FRAME_DIV(FD), .SCORE_W(4)) dut_s (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame(i_frame), .i_start(i_start), .i_pause(i_pause),
        .i_p_x1(p_x1), .i_p_x2(p_x2), .i_p_y1(p_y1), .i_p_y2(p_y2),
        .i_o_x1(o_x1), .i_o_x2(o_x2), .i_o_y1(o_y1), .i_o_y2(o_y2),
        .o_ani_stb(s_stb), .o_animate(s_animate), .o_sprite_rst(s_srst),
        .o_state(s_state), .o_score(s_score), .o_hit(s_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_boxes(input int px1, px2, py1, py2, ox1, ox2, oy1, oy2);
        p_x1 = 12'(px1); p_x2 = 12'(px2); p_y1 = 12'(py1); p_y2 = 12'(py2);
        o_x1 = 12'(ox1); o_x2 = 12'(ox2); o_y1 = 12'(oy1); o_y2 = 12'(oy2);
    endtask

    function automatic bit model_hit();
        int px1 = int'(p_x1), px2 = int'(p_x2), py1 = int'(p_y1), py2 = int'(p_y2);
        int ox1 = int'(o_x1), ox2 = int'(o_x2), oy1 = int'(o_y1), oy2 = int'(o_y2);
        bit overlap = (px1 < ox2) && (ox1 < px2) && (py1 < oy2) && (oy1 < py2);
        bit outside = (py1 == 0) || (py2 >= 480) || (px1 == 0) || (px2 >= 640);
        return overlap || outside;
    endfunction

    // Frames per animation step at the current score.
    function automatic int model_div();
`ifdef ANIM_CTRL_SPEEDUP_EN
        int e = FD - m_score / 256;
        return (e < 1) ? 1 : e;
`else
        return FD;
`endif
    endfunction

    // Advance the model by one clock using the inputs just sampled.
    task automatic model_update(input bit rst, input bit f, input bit s, input bit p);
        int e;
        m_stb  = 0;
        m_srst = 0;
        if (rst) begin
            m_state = 0; m_phase = 0; m_score = 0; m_score4 = 0; m_hit = 0; m_srst = 1;
        end else begin
            case (m_state)
                0, 3: if (s) begin
                    m_state = 1; m_srst = 1; m_score = 0; m_score4 = 0; m_hit = 0; m_phase = 0;
                end
                1: if (f && model_hit()) begin
                    m_state = 3;
                    m_hit   = 1;
                end else begin
                    if (f) begin
                        e = model_div();
                        m_phase++;
                        if (m_phase >= e) begin
                            m_phase = 0;
                            m_stb   = 1;
                            if (m_score < 65535) m_score++;
                            if (m_score4 < 15) m_score4++;
                        end
                    end
                    if (p) m_state = 2;
                end
                2: if (p) m_state = 1;
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: drive inputs, step the model at the edge, check at the falling edge.
    task automatic cyc(input bit rst, input bit f, input bit s, input bit p);
        i_rst = rst; i_frame = f; i_start = s; i_pause = p;
        @(posedge i_clk);
        model_update(rst, f, s, p);
        @(negedge i_clk);
        chk("state", 32'(state), m_state);
        chk("ani_stb", 32'(stb), m_stb);
        chk("animate", 32'(animate), (m_state == 1) ? 1 : 0);
        chk("sprite_rst", 32'(srst), m_srst);
        chk("score", 32'(score), m_score);
        chk("hit", 32'(hit), m_hit);
        chk("score4", 32'(s_score), m_score4);
        if (stb === 1'b1) stb_seen++;
    endtask

    initial begin
        int guard;
        i_rst = 1'b1; i_frame = 1'b0; i_start = 1'b0; i_pause = 1'b0;
        set_boxes(100, 140, 100, 140, 300, 340, 300, 340);
        @(negedge i_clk);

        // Reset, then ignored pause/frame in IDLE.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("reset_sprite_rst", 32'(srst), 1);
        chk("reset_state", 32'(state), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        chk("idle_holds", 32'(state), 0);

        // Start: one-cycle sprite reset, RUN, score cleared.
        cyc(0, 0, 1, 0);
        chk("start_sprite_rst", 32'(srst), 1);
        chk("start_state", 32'(state), 1);
        chk("start_score", 32'(score), 0);
        cyc(0, 0, 0, 0);
        chk("sprite_rst_one_cycle", 32'(srst), 0);

        // Nine frames with FRAME_DIV=3 give three strobes.
        stb_seen = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("nine_frame_strobes", stb_seen, 3);
        chk("nine_frame_score", 32'(score), 3);

        // Pause with divider at phase 1; frames while paused do nothing.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("paused", 32'(state), 2);
        stb_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("pause_no_strobe", stb_seen, 0);
        cyc(0, 0, 0, 1);
        chk("resumed", 32'(state), 1);
        cyc(0, 1, 0, 0);
        chk("resume_phase_a", 32'(stb), 0);
        cyc(0, 1, 0, 0);
        chk("resume_phase_b", 32'(stb), 1);

        // Touching edge is not a hit; one pixel overlap is.
        set_boxes(100, 140, 100, 140, 140, 200, 0, 480);
        cyc(0, 1, 0, 0);
        chk("touch_no_hit", 32'(hit), 0);
        set_boxes(100, 140, 100, 140, 139, 200, 0, 480);
        cyc(0, 1, 0, 0);
        chk("hit_state", 32'(state), 3);
        chk("hit_flag", 32'(hit), 1);
        chk("hit_no_strobe", 32'(stb), 0);
        cyc(0, 1, 0, 1);
        chk("over_ignores_pause", 32'(state), 3);

        // Restart, then frame + hit + pause together: hit wins.
        cyc(0, 0, 1, 0);
        chk("restart_hit", 32'(hit), 0);
        cyc(0, 1, 0, 1);
        chk("hit_beats_pause", 32'(state), 3);
        cyc(0, 0, 1, 0);
        chk("restart_state", 32'(state), 1);
        chk("restart_score", 32'(score), 0);

        // Out of bounds at the left edge.
        set_boxes(0, 40, 100, 140, 300, 340, 300, 340);
        cyc(0, 1, 0, 0);
        chk("oob_state", 32'(state), 3);
        set_boxes(100, 140, 100, 140, 300, 340, 300, 340);

        // Reset mid-RUN discards the strobe that frame would have produced.
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("reset_drops_strobe", 32'(stb), 0);
        cyc(0, 0, 1, 1);
        chk("start_beats_pause", 32'(state), 1);

        // Twenty steps: 4-bit score saturates at 15.
        for (int i = 0; i < 20 * FD; i++) cyc(0, 1, 0, 0);
        chk("sat_score4", 32'(s_score), 15);
        chk("score_20", 32'(score), 20);

        // Random play.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                int a = $urandom_range(0, 600), b = $urandom_range(0, 440);
                int c = $urandom_range(0, 600), d = $urandom_range(0, 440);
                set_boxes(a, a + $urandom_range(1, 60), b, b + $urandom_range(1, 60),
                          c, c + $urandom_range(1, 60), d, d + $urandom_range(1, 60));
            end
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0);
        end

        // Score to 256, then measure the strobe rate over eight frames.
        set_boxes(100, 140, 100, 140, 300, 340, 300, 340);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        guard = 0;
        while (m_score < 256 && guard < 2000) begin
            cyc(0, 1, 0, 0);
            guard++;
        end
        chk("reach_256", 32'(score), 256);
        stb_seen = 0;
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
`ifdef ANIM_CTRL_SPEEDUP_EN
        chk("speedup_rate", stb_seen, 4);
`else
        chk("fixed_rate", stb_seen, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/anim_ctrl.md
ANIM_CTRL -- requirements
Module: anim_ctrl

Interface
- REQ-001 The block SHALL have parameter D_WIDTH, default 640: display width in pixels.
- REQ-002 The block SHALL have parameter D_HEIGHT, default 480: display height in pixels.
- REQ-003 The block SHALL have parameter FRAME_DIV, default 1: frames per animation step, legal range 1-15.
- REQ-004 The block SHALL have parameter SCORE_W, default 16: score counter width.
- REQ-005 The block SHALL have port i_clk, input, 1: base clock.
- REQ-006 The block SHALL have port i_rst, input, 1: reset, synchronous, active-high.
- REQ-007 The block SHALL have port i_frame, input, 1: one-cycle pulse at end of active video.
- REQ-008 The block SHALL have port i_start, input, 1: one-cycle start/restart pulse.
- REQ-009 The block SHALL have port i_pause, input, 1: one-cycle pause-toggle pulse.
- REQ-010 The block SHALL have ports i_p_x1, i_p_x2, i_p_y1, i_p_y2, input, 12 each: player box edges.
- REQ-011 The block SHALL have ports i_o_x1, i_o_x2, i_o_y1, i_o_y2, input, 12 each: obstacle box edges.
- REQ-012 The block SHALL have port o_ani_stb, output, 1: one-cycle animation strobe to sprites.
- REQ-013 The block SHALL have port o_animate, output, 1: high while in RUN.
- REQ-014 The block SHALL have port o_sprite_rst, output, 1: one-cycle reset pulse to sprites.
- REQ-015 The block SHALL have port o_state, output, 2: current state.
- REQ-016 The block SHALL have port o_score, output, SCORE_W: completed animation steps.
- REQ-017 The block SHALL have port o_hit, output, 1: sticky game-over flag.

Function
- REQ-018 The FSM SHALL have four states: IDLE=0, RUN=1, PAUSE=2, OVER=3.
- REQ-019 i_start in IDLE or OVER SHALL move the FSM to RUN next cycle, pulse o_sprite_rst for exactly that cycle, clear o_score, clear o_hit and clear the frame divider.
- REQ-020 i_start in RUN or PAUSE SHALL be ignored.
- REQ-021 i_pause SHALL toggle RUN and PAUSE; in IDLE and OVER it SHALL be ignored.
- REQ-022 The frame divider SHALL count i_frame pulses only in RUN and SHALL hold its value in PAUSE.
- REQ-023 When the divider reaches FRAME_DIV-1, it SHALL wrap to 0 and assert o_ani_stb in the following cycle, giving 1-cycle latency from i_frame.
- REQ-024 Each o_ani_stb SHALL increment o_score, saturating at all-ones with no wrap.
- REQ-025 Collision SHALL be true when i_p_x1<i_o_x2 AND i_o_x1<i_p_x2 AND i_p_y1<i_o_y2 AND i_o_y1<i_p_y2, all comparisons strict and unsigned.
- REQ-026 Out-of-bounds SHALL be true when i_p_y1==0, i_p_y2>=D_HEIGHT, i_p_x1==0, or i_p_x2>=D_WIDTH.
- REQ-027 Collision and out-of-bounds SHALL be sampled only in cycles where i_frame is high and the state is RUN.
- REQ-028 On such a sample, collision or out-of-bounds SHALL move the FSM to OVER, set o_hit, and suppress that frame's o_ani_stb and score increment.
- REQ-029 When i_frame, a hit and i_pause occur in the same cycle, the hit SHALL win and the FSM SHALL go to OVER.
- REQ-030 When i_start and i_pause occur in the same cycle in IDLE, i_start SHALL win.
- REQ-031 o_animate SHALL equal (state==RUN) and SHALL be registered.

Reset
- REQ-032 i_rst SHALL override all other inputs in the same cycle.
- REQ-033 On reset the outputs SHALL be: state IDLE, o_ani_stb=0, o_animate=0, o_score=0, o_hit=0, divider=0.
- REQ-034 On reset o_sprite_rst SHALL be 1 for the reset cycle(s).
- REQ-035 Reset mid-RUN SHALL abandon any pending strobe.

Configuration
- REQ-036 When ANIM_CTRL_SPEEDUP_EN is defined, the effective divider SHALL be max(1, FRAME_DIV - o_score[SCORE_W-1:8]), shortening it by 1 every 256 points.
- REQ-037 When ANIM_CTRL_SPEEDUP_EN is undefined, the effective divider SHALL be FRAME_DIV at all times.

Structure
- REQ-038 The shared package anim_pkg SHALL hold the state enum, the coordinate width constant (12) and the box edge struct.
- REQ-039 A combinational sub-module rect_overlap (two boxes in, overlap out) SHALL be instantiated once.

Verification
- REQ-040 Bench SHALL drive reset, then i_start -> o_sprite_rst is 1 for 1 cycle, o_state=1 next cycle, o_score=0.
- REQ-041 Bench SHALL use FRAME_DIV=3 and 9 i_frame pulses in RUN with disjoint boxes -> 3 o_ani_stb, each 1 cycle after the 3rd, 6th and 9th frame, and o_score=3.
- REQ-042 Bench SHALL apply i_pause, 4 frames, then i_pause -> no strobes while paused and divider phase preserved on resume.
- REQ-043 Bench SHALL set player (100,140,100,140) and obstacle (139,200,0,480), then pulse i_frame -> OVER, o_hit=1, no strobe; obstacle x1=140 instead -> no hit.
- REQ-044 Bench SHALL apply i_frame, a hit and i_pause in the same cycle -> OVER; then i_start -> RUN, o_hit=0, o_score=0.
- REQ-045 Bench SHALL use SCORE_W=4 with 20 steps -> o_score holds 15; with ANIM_CTRL_SPEEDUP_EN, FRAME_DIV=3, score 256 -> strobe every 2 frames.
